mm_mem_access: RTL and testbench
================================

Name: mm_mem_access

Overview:
- MEM-stage memory-access controller of the dual-issue pipeline. Sits directly downstream of the EX->MM pipeline register and consumes its line valids and data bus.
- Issues at most one load/store per stage occupancy, on line1 only, to the sram-like data port: req/addr_ok/data_ok.
- Produces now_allowin for the EX->MM register and the per-line valids toward the MM->WB register.
- Absorbs responses orphaned by exception flushes.

Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, data word width; only 32 is supported

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- line1_valid_i  in  1  line1 occupancy, from the EX->MM register valid
- line2_valid_i  in  1  line2 occupancy
- next_allowin_i  in  1  MM->WB register can accept
- now_allowin_o  out  1  to the EX->MM register now_allowin_i
- line1_to_next_valid_o  out  1  line1 ready toward WB
- line2_to_next_valid_o  out  1  line2 ready toward WB
- excep_flush_i  in  1  exception flush
- mem_en_i  in  1  line1 carries a load/store
- mem_we_i  in  1  1 = store
- mem_size_i  in  2  0 = byte, 1 = half, 2 = word
- mem_addr_i  in  ADDR_W  effective address
- mem_wdata_i  in  DATA_W  store data, right-aligned
- line1_excep_en_i  in  1  line1 already faulted; suppresses the access
- data_sram_req_o  out  1  request
- data_sram_wr_o  out  1  write
- data_sram_size_o  out  2  size
- data_sram_wstrb_o  out  4  byte strobes
- data_sram_addr_o  out  ADDR_W  address
- data_sram_wdata_o  out  DATA_W  lane-replicated store data
- data_sram_addr_ok_i  in  1  request accepted
- data_sram_data_ok_i  in  1  response/ack
- data_sram_rdata_i  in  DATA_W  read data
- load_rdata_o  out  DATA_W  raw read word toward WB

Behaviour:
- need_req = line1_valid_i & mem_en_i & ~line1_excep_en_i & ~excep_flush_i.
- States: IDLE, REQ, WAIT, HOLD, DROP. Reset: state = IDLE, rdata_q = 0. All outputs at reset are combinational from IDLE with the valids at 0: req = 0, now_allowin = 1, to_next valids = 0.
- data_sram_req_o = need_req & (state == IDLE | state == REQ). Address, size, wr, wstrb and wdata are driven combinationally from the inputs and are valid whenever req = 1.
- IDLE / REQ:
  - need_req & addr_ok -> WAIT.
  - need_req & ~addr_ok -> REQ.
  - ~need_req -> IDLE.
  - The request must not drop while in REQ unless excep_flush_i is asserted.
- WAIT:
  - data_ok & next_allowin_i -> IDLE; the stage retires that cycle.
  - data_ok & ~next_allowin_i -> HOLD, with rdata_q <= rdata.
  - excep_flush_i & ~data_ok -> DROP.
  - excep_flush_i & data_ok -> IDLE, response discarded.
- HOLD: next_allowin_i -> IDLE. excep_flush_i -> IDLE.
- DROP:
  - Waits for data_ok and discards it, then -> IDLE.
  - now_allowin_o = 0 throughout DROP, so a newly flushed-in access cannot pair with a stale response.
- ready_go = ~(line1_valid_i & mem_en_i & ~line1_excep_en_i) | (state == WAIT & data_ok) | state == HOLD.
- now_allowin_o = (state != DROP) & (~(line1_valid_i | line2_valid_i) | (ready_go & next_allowin_i)).
- lineN_to_next_valid_o = lineN_valid_i & ready_go & ~excep_flush_i.
- load_rdata_o = data_sram_rdata_i in WAIT; rdata_q otherwise.
- Stores complete on data_ok in the same way as loads.
- wstrb:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
  - wdata for byte = {4{wdata[7:0]}}; for half = {2{wdata[15:0]}}.
  - Misalignment is excluded: it is raised as ALE upstream and arrives as line1_excep_en_i.
- Line2 never accesses memory; it stalls with line1.
- A response arriving in IDLE or REQ is a protocol error and is ignored.

Optional Feature:
- Macro MM_STALL_CNT_EN.
- Defined: adds output port stall_cnt_o[31:0], which increments each cycle (line1_valid_i | line2_valid_i) & ~ready_go. It wraps at 2^32 and resets to 0.
- Undefined: no port, no counter; all other behaviour is identical.

Decomposition:
- Shared package mm_pkg: state encoding (3-bit), size encodings (MEM_B/MEM_H/MEM_W), ADDR_W/DATA_W defaults.
- One combinational sub-module: mm_store_align, which takes size, addr[1:0] and wdata and produces wstrb and replicated wdata.

Test Plan:
- Word load at 0x1000, addr_ok same cycle, data_ok 2 cycles later with 0xDEADBEEF and next_allowin = 1 -> req high 1 cycle, line1_to_next_valid = 1 on the data_ok cycle, load_rdata_o = 0xDEADBEEF, now_allowin = 1 that cycle.
- Byte store of 0xA5 at 0x2003 -> wstrb = 4'b1000, wdata = 0xA5A5A5A5, wr = 1, size = 0.
- addr_ok withheld 3 cycles -> req stays high with a stable address for 4 cycles; now_allowin = 0 until data_ok.
- data_ok while next_allowin = 0 for 2 cycles -> HOLD; load_rdata_o is held at the captured value; to_next valid asserts and is held until next_allowin; then IDLE.
- Flush in WAIT, data_ok 3 cycles later -> DROP; now_allowin = 0 and to_next valids = 0 for those cycles; no valid to WB; IDLE after data_ok.
- Dual valid with line1 non-memory and line2 valid, next_allowin = 1 -> both to_next valids = 1 in 0 cycles, req = 0; line1_excep_en = 1 with mem_en -> req = 0, passes through immediately.

Source files
------------

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mm_pkg
//  Brief    : Shared types and constants for the MEM-stage access controller:
//             FSM state encoding, access-size encodings, width defaults.
//  Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Access-size encodings as carried on mem_size_i / data_sram_size_o
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // Access FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } mm_state_e;

endpackage : mm_pkg
`default_nettype wire

// File: rtl/mm_store_align.sv
`default_nettype none
// ============================================================================
//  Module   : mm_store_align
//  Brief    : Builds byte strobes and lane-replicated store data from the
//             access size and the low address bits. Purely combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module mm_store_align
    import mm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep
);

    // Select strobe pattern and replicate the right-aligned data to every lane
    always_comb begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        case (size)
            MEM_B: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_H: begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                // Word (and the unused encoding 3) write the whole word
                wstrb     = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

endmodule : mm_store_align
`default_nettype wire

// File: rtl/mm_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : mm_mem_access
//  Brief    : MEM-stage memory-access controller of the dual-issue pipeline.
//             Issues one load/store per stage occupancy on line1 over an
//             sram-like req/addr_ok/data_ok port, generates the stage
//             handshake, and swallows responses orphaned by flushes.
//  Options  : MM_STALL_CNT_EN - adds stall_cnt_o, a free-running count of
//             cycles where the stage is occupied but not ready to go.
//  Revision : 1.0 - initial release
// ============================================================================
module mm_mem_access
    import mm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF   // only 32 is supported
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line1_valid_i,
    input  logic              line2_valid_i,
    input  logic              next_allowin_i,
    output logic              now_allowin_o,
    output logic              line1_to_next_valid_o,
    output logic              line2_to_next_valid_o,
    input  logic              excep_flush_i,
    input  logic              mem_en_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              line1_excep_en_i,
    output logic              data_sram_req_o,
    output logic              data_sram_wr_o,
    output logic [1:0]        data_sram_size_o,
    output logic [3:0]        data_sram_wstrb_o,
    output logic [ADDR_W-1:0] data_sram_addr_o,
    output logic [DATA_W-1:0] data_sram_wdata_o,
    input  logic              data_sram_addr_ok_i,
    input  logic              data_sram_data_ok_i,
    input  logic [DATA_W-1:0] data_sram_rdata_i,
    output logic [DATA_W-1:0] load_rdata_o
`ifdef MM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    mm_state_e          r_state;
    mm_state_e          w_next_state;
    logic [DATA_W-1:0]  r_rdata_q;
    logic               w_capture;
    logic               w_mem_op;
    logic               w_need_req;
    logic               w_ready_go;

    // line1 holds an access that is allowed to touch memory
    assign w_mem_op   = line1_valid_i & mem_en_i & ~line1_excep_en_i;
    assign w_need_req = w_mem_op & ~excep_flush_i;

    // Request fields follow the inputs directly; meaningful only while req = 1
    assign data_sram_req_o  = w_need_req & ((r_state == ST_IDLE) | (r_state == ST_REQ));
    assign data_sram_wr_o   = mem_we_i;
    assign data_sram_size_o = mem_size_i;
    assign data_sram_addr_o = mem_addr_i;

    mm_store_align u_store_align (
        .size      (mem_size_i),
        .addr_lo   (mem_addr_i[1:0]),
        .wdata     (mem_wdata_i),
        .wstrb     (data_sram_wstrb_o),
        .wdata_rep (data_sram_wdata_o)
    );

    // Stage may advance once its access has its response (or has none)
    assign w_ready_go = ~w_mem_op
                      | ((r_state == ST_WAIT) & data_sram_data_ok_i)
                      | (r_state == ST_HOLD);

    // DROP blocks new entries so a fresh access never meets a stale response
    assign now_allowin_o = (r_state != ST_DROP)
                         & (~(line1_valid_i | line2_valid_i) | (w_ready_go & next_allowin_i));

    assign line1_to_next_valid_o = line1_valid_i & w_ready_go & ~excep_flush_i;
    assign line2_to_next_valid_o = line2_valid_i & w_ready_go & ~excep_flush_i;

    // Live response while waiting, otherwise the word parked by HOLD
    assign load_rdata_o = (r_state == ST_WAIT) ? data_sram_rdata_i : r_rdata_q;

    // Next-state logic; responses in IDLE/REQ are protocol errors and ignored
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE, ST_REQ: begin
                if (w_need_req & data_sram_addr_ok_i) w_next_state = ST_WAIT;
                else if (w_need_req)                  w_next_state = ST_REQ;
                else                                  w_next_state = ST_IDLE;
            end
            ST_WAIT: begin
                if (data_sram_data_ok_i) begin
                    if (excep_flush_i | next_allowin_i) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_HOLD;
                        w_capture    = 1'b1;
                    end
                end else if (excep_flush_i) begin
                    w_next_state = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (next_allowin_i | excep_flush_i) w_next_state = ST_IDLE;
            end
            ST_DROP: begin
                if (data_sram_data_ok_i) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register and held read word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rdata_q <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) r_rdata_q <= data_sram_rdata_i;
        end
    end

`ifdef MM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count occupied-but-not-ready cycles; wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((line1_valid_i | line2_valid_i) & ~w_ready_go) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule : mm_mem_access
`default_nettype wire

// File: tb/tb_mm_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm_mem_access
//  Brief    : Self-checking bench for mm_mem_access: table of combinational
//             vectors applied in IDLE, then hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mm_mem_access;

    logic        clk;
    logic        rst_n;
    logic        l1v, l2v, nal, flush, men, we, exc;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        aok, dok;
    logic [31:0] rdata;
    logic        allow, v1, v2, req, wr;
    logic [1:0]  osize;
    logic [3:0]  wstrb;
    logic [31:0] oaddr, owdata, ldata;
`ifdef MM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mm_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .line1_valid_i         (l1v),
        .line2_valid_i         (l2v),
        .next_allowin_i        (nal),
        .now_allowin_o         (allow),
        .line1_to_next_valid_o (v1),
        .line2_to_next_valid_o (v2),
        .excep_flush_i         (flush),
        .mem_en_i              (men),
        .mem_we_i              (we),
        .mem_size_i            (size),
        .mem_addr_i            (addr),
        .mem_wdata_i           (wdata),
        .line1_excep_en_i      (exc),
        .data_sram_req_o       (req),
        .data_sram_wr_o        (wr),
        .data_sram_size_o      (osize),
        .data_sram_wstrb_o     (wstrb),
        .data_sram_addr_o      (oaddr),
        .data_sram_wdata_o     (owdata),
        .data_sram_addr_ok_i   (aok),
        .data_sram_data_ok_i   (dok),
        .data_sram_rdata_i     (rdata),
        .load_rdata_o          (ldata)
`ifdef MM_STALL_CNT_EN
        ,
        .stall_cnt_o           (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        l1v, l2v, nal, flush, men, we, exc;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        logic        e_req, e_wr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        e_allow, e_v1, e_v2;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        l1v = 0; l2v = 0; nal = 1; flush = 0; men = 0; we = 0; exc = 0;
        size = 2'd2; addr = 32'h0; wdata = 32'h0; aok = 0; dok = 0;
    endtask

    task automatic set_load(input logic [31:0] a);
        l1v = 1; men = 1; we = 0; size = 2'd2; addr = a; exc = 0;
    endtask

    initial begin
        // l1v l2v nal fl men we exc size addr wdata | req wr wstrb wdata allow v1 v2
        vecs[0] = '{0,0,1,0,0,0,0,2'd2,32'h0,      32'h0,      0,0,4'b1111,32'h0,      1,0,0};
        vecs[1] = '{1,0,1,0,1,0,0,2'd2,32'h1000,   32'h0,      1,0,4'b1111,32'h0,      0,0,0};
        vecs[2] = '{1,0,1,0,1,1,0,2'd0,32'h2003,   32'h000000A5,1,1,4'b1000,32'hA5A5A5A5,0,0,0};
        vecs[3] = '{1,0,1,0,1,1,0,2'd1,32'h2002,   32'h00001234,1,1,4'b1100,32'h12341234,0,0,0};
        vecs[4] = '{1,0,1,0,1,1,0,2'd0,32'h2001,   32'h0000003C,1,1,4'b0010,32'h3C3C3C3C,0,0,0};
        vecs[5] = '{1,1,1,0,0,0,0,2'd2,32'h0,      32'h0,      0,0,4'b1111,32'h0,      1,1,1};
        vecs[6] = '{1,0,1,0,1,0,1,2'd2,32'h3000,   32'h0,      0,0,4'b1111,32'h0,      1,1,0};
        vecs[7] = '{1,1,1,1,1,0,0,2'd2,32'h3000,   32'h0,      0,0,4'b1111,32'h0,      0,0,0};
        vecs[8] = '{1,0,0,0,0,0,0,2'd2,32'h0,      32'h0,      0,0,4'b1111,32'h0,      0,1,0};
        vecs[9] = '{0,1,0,0,0,0,0,2'd1,32'h0006,   32'h0000BEEF,0,0,4'b1100,32'hBEEFBEEF,0,0,1};

        idle_inputs();
        rdata = 32'h0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req",   {31'b0, req},   32'd0);
        chk("rst_allow", {31'b0, allow}, 32'd1);
        chk("rst_v1",    {31'b0, v1},    32'd0);
        chk("rst_v2",    {31'b0, v2},    32'd0);
        chk("rst_ldata", ldata,          32'd0);
        rst_n = 1;

        // Combinational vectors: inputs return to idle before every posedge
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            l1v = vecs[i].l1v; l2v = vecs[i].l2v; nal = vecs[i].nal;
            flush = vecs[i].flush; men = vecs[i].men; we = vecs[i].we;
            exc = vecs[i].exc; size = vecs[i].size; addr = vecs[i].addr;
            wdata = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_req", i),   {31'b0, req},   {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_wr", i),    {31'b0, wr},    {31'b0, vecs[i].e_wr});
            chk($sformatf("v%0d_size", i),  {30'b0, osize}, {30'b0, vecs[i].size});
            chk($sformatf("v%0d_addr", i),  oaddr,          vecs[i].addr);
            chk($sformatf("v%0d_wstrb", i), {28'b0, wstrb}, {28'b0, vecs[i].e_wstrb});
            chk($sformatf("v%0d_wdata", i), owdata,         vecs[i].e_wdata);
            chk($sformatf("v%0d_allow", i), {31'b0, allow}, {31'b0, vecs[i].e_allow});
            chk($sformatf("v%0d_v1", i),    {31'b0, v1},    {31'b0, vecs[i].e_v1});
            chk($sformatf("v%0d_v2", i),    {31'b0, v2},    {31'b0, vecs[i].e_v2});
            idle_inputs();
        end

        // A: word load, addr_ok at once, data_ok two cycles later
        @(negedge clk); set_load(32'h1000); aok = 1;
        #1; chk("A_req", {31'b0, req}, 32'd1); chk("A_allow", {31'b0, allow}, 32'd0);
        @(negedge clk); aok = 0;
        #1; chk("A_wait_req", {31'b0, req}, 32'd0); chk("A_wait_v1", {31'b0, v1}, 32'd0);
        chk("A_wait_allow", {31'b0, allow}, 32'd0);
        @(negedge clk); dok = 1; rdata = 32'hDEADBEEF;
        #1; chk("A_dok_v1", {31'b0, v1}, 32'd1); chk("A_dok_ldata", ldata, 32'hDEADBEEF);
        chk("A_dok_allow", {31'b0, allow}, 32'd1);
        @(negedge clk); idle_inputs(); rdata = 32'h55555555;
        #1; chk("A_idle_ldata", ldata, 32'h0); chk("A_idle_allow", {31'b0, allow}, 32'd1);

        // B: addr_ok withheld three cycles; request and address stay stable
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); set_load(32'h3000); aok = (c == 3);
            #1;
            chk($sformatf("B_req%0d", c),   {31'b0, req},   32'd1);
            chk($sformatf("B_addr%0d", c),  oaddr,          32'h3000);
            chk($sformatf("B_allow%0d", c), {31'b0, allow}, 32'd0);
        end
        @(negedge clk); aok = 0; dok = 1; rdata = 32'h0BADF00D;
        #1; chk("B_dok_allow", {31'b0, allow}, 32'd1); chk("B_dok_v1", {31'b0, v1}, 32'd1);
        @(negedge clk); idle_inputs();

        // C: response while WB is stalled -> HOLD keeps the word
        @(negedge clk); set_load(32'h4000); aok = 1;
        @(negedge clk); aok = 0; dok = 1; rdata = 32'h11223344; nal = 0;
        #1; chk("C_dok_v1", {31'b0, v1}, 32'd1); chk("C_dok_allow", {31'b0, allow}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); dok = 0; rdata = 32'hFFFFFFFF;
            #1;
            chk($sformatf("C_hold_ldata%0d", c), ldata,          32'h11223344);
            chk($sformatf("C_hold_v1_%0d", c),   {31'b0, v1},    32'd1);
            chk($sformatf("C_hold_allow%0d", c), {31'b0, allow}, 32'd0);
            chk($sformatf("C_hold_req%0d", c),   {31'b0, req},   32'd0);
        end
        @(negedge clk); nal = 1;
        #1; chk("C_rel_v1", {31'b0, v1}, 32'd1); chk("C_rel_allow", {31'b0, allow}, 32'd1);
        @(negedge clk); idle_inputs();
        #1; chk("C_idle_allow", {31'b0, allow}, 32'd1);

        // D: flush while waiting -> DROP until the orphan response arrives
        @(negedge clk); set_load(32'h5000); aok = 1;
        @(negedge clk); aok = 0; flush = 1;
        #1; chk("D_fl_v1", {31'b0, v1}, 32'd0); chk("D_fl_allow", {31'b0, allow}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); idle_inputs(); dok = (c == 2); rdata = 32'hCAFEF00D;
            if (c == 1) begin set_load(32'h6000); l2v = 1; end
            #1;
            chk($sformatf("D_drop_allow%0d", c), {31'b0, allow}, 32'd0);
            chk($sformatf("D_drop_req%0d", c),   {31'b0, req},   32'd0);
            chk($sformatf("D_drop_v2_%0d", c),   {31'b0, v2},    32'd0);
        end
        @(negedge clk); idle_inputs(); rdata = 32'h0;
        #1; chk("D_idle_allow", {31'b0, allow}, 32'd1); chk("D_idle_ldata", ldata, 32'h11223344);

        // E: stray response in IDLE is ignored; next load still issues
        @(negedge clk); dok = 1; rdata = 32'h77777777;
        @(negedge clk); dok = 0; set_load(32'h7000);
        #1; chk("E_req", {31'b0, req}, 32'd1); chk("E_ldata", ldata, 32'h11223344);
        @(negedge clk); idle_inputs();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mm_mem_access
`default_nettype wire
